// File: rtl/s2_cell_scheduler_pkg.sv
// Shared definitions for the s2 cell scheduler: default sizing, FSM
// encoding and the select function of the s2 logic cell.
package s2_cell_scheduler_pkg;

   localparam int N_DEF  = 4;
   localparam int IW_DEF = 2;

   // 2'b11 is not a legal state; the FSM falls back to IDLE from it.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_DRIVE = 2'b01,
      ST_RESP  = 2'b10
   } state_t;

   // Cell select: high bit from the OR pair, low bit from the AND pair.
   function automatic logic [1:0] cell_sel(input logic a0, input logic b0,
                                           input logic a1, input logic b1);
      return {a1 | b1, a0 & b0};
   endfunction

endpackage

// File: rtl/s2_cell_scheduler_if.sv
// Requester-side bundle of the s2 cell scheduler.
//
// Handshake: a requester raises req[i] (level) with its operands on d_in,
// a0_in, b0_in, a1_in and b1_in. Operands are sampled only on the grant edge.
// req[i] is held until ack[i] pulses for one cycle with result valid in that
// same cycle; req[i] still high on the cycle after ack[i] is a new request.
// Dropping req[i] before its grant withdraws it; after the grant the
// operation completes and ack[i] still pulses.
interface s2_cell_scheduler_if #(parameter int N = 4);
   import s2_cell_scheduler_pkg::*;

   logic [N-1:0]   req;
   logic [4*N-1:0] d_in;
   logic [N-1:0]   a0_in;
   logic [N-1:0]   b0_in;
   logic [N-1:0]   a1_in;
   logic [N-1:0]   b1_in;
   logic [N-1:0]   gnt;
   logic [N-1:0]   ack;
   logic           result;
   logic           busy;
   state_t         state;

   modport master (
      output req, d_in, a0_in, b0_in, a1_in, b1_in,
      input  gnt, ack, result, busy, state
   );

   modport slave (
      input  req, d_in, a0_in, b0_in, a1_in, b1_in,
      output gnt, ack, result, busy, state
   );

endinterface

// File: rtl/s2.sv
// The s2 logic cell: a 4-input function table indexed by the select pair,
// with a registered output.
module s2
   import s2_cell_scheduler_pkg::*;
(
   input  logic       clk,
   input  logic       clr,
   input  logic [3:0] d,
   input  logic       a0,
   input  logic       b0,
   input  logic       a1,
   input  logic       b1,
   output logic       q
);

   // Register the table entry picked by the select terms.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) q <= 1'b0;
      else      q <= d[cell_sel(a0, b0, a1, b1)];
   end

endmodule

// File: rtl/s2_cell_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr and wraps upward,
// the first asserted request wins.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [IW-1:0] j;

   // Rotating priority scan from the pointer.
   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      j   = '0;
      for (int i = 0; i < N; i++) begin
         j = IW'((int'(ptr) + i) % N);
         if (!any && req[j]) begin
            any    = 1'b1;
            gnt[j] = 1'b1;
            idx    = j;
         end
      end
   end

endmodule

// File: rtl/s2_cell_scheduler.sv
// Time-shares one s2 cell among N requesters. IDLE picks a winner and
// latches its operands, DRIVE lets the cell register the result, RESP acks
// the winner and may immediately start the next operation.
module s2_cell_scheduler
   import s2_cell_scheduler_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int IW = IW_DEF
) (
   input  logic              clk,
   input  logic              clr,
   s2_cell_scheduler_if.slave bus
);

   state_t        state_q, state_d;
   logic          load;
   logic [IW-1:0] ptr_q, win_q;
   logic [3:0]    d_q;
   logic          a0_q, b0_q, a1_q, b1_q;
   logic [N-1:0]  gnt_q, ack_q;
   logic          busy_q, hold_q, cell_q;
   logic [N-1:0]  win_mask, req_eff;
   logic [N-1:0]  arb_gnt;
   logic [IW-1:0] arb_idx;
   logic          arb_any;

   // The winner being acked may still hold req; keep it out of this round.
   assign win_mask = (state_q == ST_RESP) ? (N'(1) << win_q) : '0;
   assign req_eff  = bus.req & ~win_mask;

   rr_arbiter #(.N(N), .IW(IW)) u_arb (
      .req (req_eff),
      .ptr (ptr_q),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   s2 u_cell (
      .clk (clk),
      .clr (clr),
      .d   (d_q),
      .a0  (a0_q),
      .b0  (b0_q),
      .a1  (a1_q),
      .b1  (b1_q),
      .q   (cell_q)
   );

   // Next-state and operand-load decision.
   always_comb begin
      state_d = ST_IDLE;
      load    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (arb_any) begin
               state_d = ST_DRIVE;
               load    = 1'b1;
            end
         end
         ST_DRIVE: state_d = ST_RESP;
         ST_RESP: begin
            if (arb_any) begin
               state_d = ST_DRIVE;
               load    = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   // Operand, winner and pointer capture on every grant.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         d_q   <= '0;
         a0_q  <= 1'b0;
         b0_q  <= 1'b0;
         a1_q  <= 1'b0;
         b1_q  <= 1'b0;
         win_q <= '0;
         ptr_q <= '0;
      end else if (load) begin
         d_q   <= bus.d_in[{arb_idx, 2'b00} +: 4];
         a0_q  <= bus.a0_in[arb_idx];
         b0_q  <= bus.b0_in[arb_idx];
         a1_q  <= bus.a1_in[arb_idx];
         b1_q  <= bus.b1_in[arb_idx];
         win_q <= arb_idx;
         ptr_q <= (arb_idx == IW'(N - 1)) ? '0 : arb_idx + IW'(1);
      end
   end

   // Registered status outputs derived from the next state.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         gnt_q  <= '0;
         ack_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         busy_q <= (state_d != ST_IDLE);
         ack_q  <= (state_d == ST_RESP) ? (N'(1) << win_q) : '0;
         if (load)                   gnt_q <= arb_gnt;
         else if (state_d == ST_IDLE) gnt_q <= '0;
      end
   end

   // Keep the last delivered result visible between operations.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr)        hold_q <= 1'b0;
      else if (|ack_q) hold_q <= cell_q;
   end

   assign bus.gnt    = gnt_q;
   assign bus.ack    = ack_q;
   assign bus.busy   = busy_q;
   assign bus.result = (|ack_q) ? cell_q : hold_q;
   assign bus.state  = state_q;

endmodule

// File: tb/tb_s2_cell_scheduler.sv
// Directed bench for s2_cell_scheduler with an ack scoreboard.
module tb_s2_cell_scheduler;
   import s2_cell_scheduler_pkg::*;

   localparam int N = 4;
   localparam int W = 21;  // {ack cycle[15:0], ack vector[3:0], result}

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic [15:0] cyc = '0;
   int          checks = 0;
   int          failures = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] mon_e;
   logic [N-1:0] drop_mask;
   logic [15:0]  c;

   s2_cell_scheduler_if #(.N(N)) bus();

   s2_cell_scheduler #(.N(N), .IW(2)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   // Clock and cycle counter.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 16'd1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input logic [15:0] ack_cyc, input int idx, input logic res);
      logic [3:0] oh;
      oh = '0;
      oh[idx] = 1'b1;
      exp_q.push_back({ack_cyc, oh, res});
   endtask

   task automatic set_ops(input int i, input logic [3:0] d, input logic a0, input logic b0,
                          input logic a1, input logic b1);
      bus.d_in[4*i +: 4] = d;
      bus.a0_in[i] = a0;
      bus.b0_in[i] = b0;
      bus.a1_in[i] = a1;
      bus.b1_in[i] = b1;
   endtask

   // One cycle of the requester driver; drops req after its ack where enabled.
   task automatic step();
      @(negedge clk);
      bus.req = bus.req & ~(bus.ack & drop_mask);
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         step();
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout: %0d acks outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // Scoreboard monitor: every ack must match the head of the expected queue.
   always @(negedge clk) begin
      if (clr && bus.ack != '0) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ack: got ack %b at cycle %0d, required none", bus.ack, cyc);
         end else begin
            mon_e = exp_q.pop_front();
            check("ack_cycle", 32'(cyc), 32'(mon_e[20:5]));
            check("ack_vec", 32'(bus.ack), 32'(mon_e[4:1]));
            check("ack_result", 32'(bus.result), 32'(mon_e[0]));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

   initial begin
      bus.req   = '0;
      bus.d_in  = '0;
      bus.a0_in = '0;
      bus.b0_in = '0;
      bus.a1_in = '0;
      bus.b1_in = '0;
      drop_mask = 4'b1111;
      // r0: sel=01 of 1010 -> 1; r1: sel=10 of 0100 -> 1
      // r2: sel=00 of 1110 -> 0; r3: sel=11 of 0111 -> 0
      set_ops(0, 4'b1010, 1'b1, 1'b1, 1'b0, 1'b0);
      set_ops(1, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b0);
      set_ops(2, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0);
      set_ops(3, 4'b0111, 1'b1, 1'b1, 1'b0, 1'b1);

      // Reset held with all requesting.
      bus.req = 4'b1111;
      repeat (3) step();
      check("rst_gnt", 32'(bus.gnt), 32'h0);
      check("rst_ack", 32'(bus.ack), 32'h0);
      check("rst_result", 32'(bus.result), 32'h0);
      check("rst_busy", 32'(bus.busy), 32'h0);

      // Release: all four served in order 0..3, two cycles apart.
      step();
      clr = 1'b1;
      c = cyc;
      push(c + 16'd2, 0, 1'b1);
      push(c + 16'd4, 1, 1'b1);
      push(c + 16'd6, 2, 1'b0);
      push(c + 16'd8, 3, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         step();
         check("busy_all_req", 32'(bus.busy), 32'h1);
         if (k == 3) check("gnt_drive1", 32'(bus.gnt), 32'h2);
      end
      step();
      check("busy_after_all", 32'(bus.busy), 32'h0);
      drain(4);

      // Fairness: req0 held, req2 re-raised after each ack.
      drop_mask = 4'b0100;
      step();
      c = cyc;
      bus.req = 4'b0101;
      push(c + 16'd2, 0, 1'b1);
      push(c + 16'd4, 2, 1'b0);
      push(c + 16'd6, 0, 1'b1);
      push(c + 16'd8, 2, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         step();
         if (k == 1) check("fair_gnt_drive0", 32'(bus.gnt), 32'h1);
         if (k == 2) check("fair_gnt_resp0", 32'(bus.gnt), 32'h1);
         if (k == 3) check("fair_gnt_drive2", 32'(bus.gnt), 32'h4);
         if (k == 5) bus.req[2] = 1'b1;
         if (k == 8) bus.req = '0;
      end
      drain(4);

      // Single request from requester 0.
      drop_mask = 4'b1111;
      step();
      c = cyc;
      bus.req = 4'b0001;
      push(c + 16'd2, 0, 1'b1);
      step();
      check("single_busy", 32'(bus.busy), 32'h1);
      step();
      step();
      check("single_idle_busy", 32'(bus.busy), 32'h0);
      check("single_idle_gnt", 32'(bus.gnt), 32'h0);
      check("single_hold", 32'(bus.result), 32'h1);
      drain(2);

      // Reset during DRIVE of requester 1.
      step();
      bus.req = 4'b0010;
      step();
      check("mid_gnt_drive1", 32'(bus.gnt), 32'h2);
      #1 clr = 1'b0;
      #1;
      check("mid_rst_gnt", 32'(bus.gnt), 32'h0);
      check("mid_rst_busy", 32'(bus.busy), 32'h0);
      check("mid_rst_result", 32'(bus.result), 32'h0);
      bus.req = 4'b0011;
      step();
      clr = 1'b1;
      c = cyc;
      push(c + 16'd2, 0, 1'b1);
      push(c + 16'd4, 1, 1'b1);
      drain(8);

      // Select coverage on requester 3: sel=11 then sel=10.
      set_ops(3, 4'b1000, 1'b1, 1'b1, 1'b0, 1'b1);
      step();
      c = cyc;
      bus.req = 4'b1000;
      push(c + 16'd2, 3, 1'b1);
      drain(4);
      set_ops(3, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b1);
      step();
      c = cyc;
      bus.req = 4'b1000;
      push(c + 16'd2, 3, 1'b0);
      step();
      set_ops(3, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b1);
      drain(4);
      step();
      check("sel10_hold", 32'(bus.result), 32'h0);
      check("final_busy", 32'(bus.busy), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
